// File: rtl/register_file_access_controller_pkg.sv
// Shared types and default widths for the register file access controller.
package rf_access_pkg;

  localparam int RF_ADDRESS_WIDTH = 5;
  localparam int RF_DATA_WIDTH    = 32;
  localparam int RF_WB_DEPTH      = 4;

  typedef logic [RF_ADDRESS_WIDTH-1:0] rf_address_t;
  typedef logic [RF_DATA_WIDTH-1:0]    rf_data_t;

  typedef struct packed {
    rf_address_t address;
    rf_data_t    data;
  } wb_entry_t;

  // Width of a counter that must hold every value from 0 to depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/register_file_access_controller_if.sv
// Processor-side and register-file-side bus of the access controller.
interface register_file_access_controller_if
  import rf_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int WB_DEPTH      = RF_WB_DEPTH
);

  localparam int COUNT_WIDTH = count_width(WB_DEPTH);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [ADDRESS_WIDTH-1:0] wr_address;
  logic [DATA_WIDTH-1:0]    wr_data;
  logic                     rd_valid;
  logic [ADDRESS_WIDTH-1:0] rd_address;
  logic                     rsp_valid;
  logic [DATA_WIDTH-1:0]    rsp_data;
  logic                     drain_enable;
  logic                     rf_write_enable;
  logic [ADDRESS_WIDTH-1:0] rf_address_1;
  logic [DATA_WIDTH-1:0]    rf_write_data;
  logic [ADDRESS_WIDTH-1:0] rf_address_2;
  logic [DATA_WIDTH-1:0]    rf_read_data;
  logic [COUNT_WIDTH-1:0]   pending_count;

  // The processor plus the register file it sits next to.
  modport master (
    output wr_valid, wr_address, wr_data, rd_valid, rd_address,
           drain_enable, rf_read_data,
    input  wr_ready, rsp_valid, rsp_data, rf_write_enable, rf_address_1,
           rf_write_data, rf_address_2, pending_count
  );

  // The access controller itself.
  modport slave (
    input  wr_valid, wr_address, wr_data, rd_valid, rd_address,
           drain_enable, rf_read_data,
    output wr_ready, rsp_valid, rsp_data, rf_write_enable, rf_address_1,
           rf_write_data, rf_address_2, pending_count
  );

endinterface

// File: rtl/register_file_access_controller_writeback_fifo.sv
// In-order writeback buffer with an age-ordered view of every entry.
module writeback_fifo
  import rf_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int WB_DEPTH      = RF_WB_DEPTH,
  localparam int COUNT_WIDTH  = count_width(WB_DEPTH),
  localparam int PTR_WIDTH    = $clog2(WB_DEPTH)
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  input  logic                                   push_valid_i,
  input  logic [ADDRESS_WIDTH-1:0]               push_address_i,
  input  logic [DATA_WIDTH-1:0]                  push_data_i,
  input  logic                                   pop_enable_i,
  output logic                                   push_ready_o,
  output logic                                   head_valid_o,
  output logic [ADDRESS_WIDTH-1:0]               head_address_o,
  output logic [DATA_WIDTH-1:0]                  head_data_o,
  output logic [COUNT_WIDTH-1:0]                 count_o,
  output logic [WB_DEPTH-1:0]                    view_valid_o,
  output logic [WB_DEPTH-1:0][ADDRESS_WIDTH-1:0] view_address_o,
  output logic [WB_DEPTH-1:0][DATA_WIDTH-1:0]    view_data_o
);

  localparam logic [COUNT_WIDTH-1:0] FULL_COUNT = COUNT_WIDTH'(WB_DEPTH);

  logic [WB_DEPTH-1:0][ADDRESS_WIDTH-1:0] address_q;
  logic [WB_DEPTH-1:0][DATA_WIDTH-1:0]    data_q;
  logic [PTR_WIDTH-1:0]                   head_q, head_d;
  logic [PTR_WIDTH-1:0]                   tail_q, tail_d;
  logic [COUNT_WIDTH-1:0]                 count_q, count_d;
  logic                                   push, pop;

  // Readiness looks at registered occupancy only, so a full buffer refuses
  // a write even in a cycle where its head is leaving.
  assign push_ready_o   = (count_q != FULL_COUNT);
  assign head_valid_o   = (count_q != '0);
  assign push           = push_valid_i && push_ready_o;
  assign pop            = pop_enable_i && head_valid_o;
  assign head_address_o = address_q[head_q];
  assign head_data_o    = data_q[head_q];
  assign count_o        = count_q;

  // Next pointers wrap naturally at the power-of-two depth; the count alone
  // separates empty from full.
  always_comb begin
    head_d  = pop  ? head_q + PTR_WIDTH'(1) : head_q;
    tail_d  = push ? tail_q + PTR_WIDTH'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + COUNT_WIDTH'(1);
      2'b01:   count_d = count_q - COUNT_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state; reset discards everything buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset because occupancy decides what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      address_q[tail_q] <= push_address_i;
      data_q[tail_q]    <= push_data_i;
    end
  end

  // Present entries oldest-first so slot k is the k-th oldest write.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx;
    idx            = '0;
    view_valid_o   = '0;
    view_address_o = '0;
    view_data_o    = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx               = head_q + PTR_WIDTH'(k);
      view_valid_o[k]   = (COUNT_WIDTH'(k) < count_q);
      view_address_o[k] = address_q[idx];
      view_data_o[k]    = data_q[idx];
    end
  end

endmodule

// File: rtl/register_file_access_controller.sv
// Front end for data_register_file: buffered writeback plus forwarded reads.
module register_file_access_controller
  import rf_access_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_ADDRESS_WIDTH,
  parameter int DATA_WIDTH    = RF_DATA_WIDTH,
  parameter int WB_DEPTH      = RF_WB_DEPTH,
  localparam int COUNT_WIDTH  = count_width(WB_DEPTH)
) (
  input logic                              clk,
  input logic                              reset_n,
  register_file_access_controller_if.slave bus
);

  logic                                   head_valid;
  logic [ADDRESS_WIDTH-1:0]               head_address;
  logic [DATA_WIDTH-1:0]                  head_data;
  logic [COUNT_WIDTH-1:0]                 count;
  logic                                   push_ready;
  logic [WB_DEPTH-1:0]                    view_valid;
  logic [WB_DEPTH-1:0][ADDRESS_WIDTH-1:0] view_address;
  logic [WB_DEPTH-1:0][DATA_WIDTH-1:0]    view_data;
  logic                                   rsp_valid_q;
  logic [DATA_WIDTH-1:0]                  rsp_data_q, rsp_data_d;

  writeback_fifo #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .WB_DEPTH     (WB_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset_n       (reset_n),
    .push_valid_i  (bus.wr_valid),
    .push_address_i(bus.wr_address),
    .push_data_i   (bus.wr_data),
    .pop_enable_i  (bus.drain_enable),
    .push_ready_o  (push_ready),
    .head_valid_o  (head_valid),
    .head_address_o(head_address),
    .head_data_o   (head_data),
    .count_o       (count),
    .view_valid_o  (view_valid),
    .view_address_o(view_address),
    .view_data_o   (view_data)
  );

  assign bus.wr_ready        = push_ready;
  assign bus.rf_write_enable = bus.drain_enable && head_valid;
  assign bus.rf_address_1    = head_address;
  assign bus.rf_write_data   = head_data;
  assign bus.rf_address_2    = bus.rd_address;
  assign bus.pending_count   = count;
  assign bus.rsp_valid       = rsp_valid_q;
  assign bus.rsp_data        = rsp_data_q;

  // Youngest buffered write to the read address wins over the register file;
  // a write arriving this same cycle is not yet buffered and is not seen.
  always_comb begin
    rsp_data_d = bus.rf_read_data;
    for (int k = 0; k < WB_DEPTH; k++) begin
      if (view_valid[k] && (view_address[k] == bus.rd_address)) begin
        rsp_data_d = view_data[k];
      end
    end
  end

  // Response register: one-cycle valid pulse, data held until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= bus.rd_valid;
      if (bus.rd_valid) begin
        rsp_data_q <= rsp_data_d;
      end
    end
  end

endmodule

// File: tb/tb_register_file_access_controller.sv
// Bench for the register file access controller with a register file model.
module tb_register_file_access_controller;
  import rf_access_pkg::*;

  localparam int WB_DEPTH = RF_WB_DEPTH;
  localparam int NUM_REGS = 32;

  logic clk = 1'b0;
  logic reset_n;

  register_file_access_controller_if bus ();

  register_file_access_controller dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Stand-in data_register_file: not reset, unwritten registers read a
  // recognisable per-register constant, combinational read port.
  rf_data_t          rf_mem [NUM_REGS];
  logic [NUM_REGS-1:0] rf_written = '0;

  function automatic rf_data_t rfInit(input int i);
    return 32'hA000_0000 | 32'(i);
  endfunction

  always @(posedge clk) begin
    if (bus.rf_write_enable) begin
      rf_mem[bus.rf_address_1]     <= bus.rf_write_data;
      rf_written[bus.rf_address_1] <= 1'b1;
    end
  end

  assign bus.rf_read_data = rf_written[bus.rf_address_2] ?
                            rf_mem[bus.rf_address_2] : rfInit(int'(bus.rf_address_2));

  // Reference model: pending writes as a queue, architectural file as an array.
  wb_entry_t pend_q[$];
  rf_data_t  ref_rf [NUM_REGS];
  rf_data_t  last_rsp;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic        wv;
    rf_address_t wa;
    rf_data_t    wd;
    logic        rv;
    rf_address_t ra;
    logic        de;
    logic        exp_ready;
    logic        exp_we;
    int          exp_cnt;
    logic        exp_rspv;
    rf_data_t    exp_rspd;
  } vec_t;

  vec_t tbl[$];

  function automatic rf_data_t modelRead(input rf_address_t a);
    rf_data_t r;
    r = ref_rf[a];
    foreach (pend_q[i]) begin
      if (pend_q[i].address == a) r = pend_q[i].data;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock of stimulus: drive just after an edge, check combinational
  // outputs mid-cycle, advance the model at the edge, check registered ones.
  task automatic applyStimulus(input logic wv, input rf_address_t wa,
                               input rf_data_t wd, input logic rv,
                               input rf_address_t ra, input logic de,
                               output logic pre_ready, output logic pre_we);
    logic      accept, drain;
    wb_entry_t ent;
    bus.wr_valid     = wv;
    bus.wr_address   = wa;
    bus.wr_data      = wd;
    bus.rd_valid     = rv;
    bus.rd_address   = ra;
    bus.drain_enable = de;
    @(negedge clk);
    pre_ready = bus.wr_ready;
    pre_we    = bus.rf_write_enable;
    accept    = wv && (pend_q.size() != WB_DEPTH);
    drain     = de && (pend_q.size() != 0);
    checkOutput("wr_ready", 32'(bus.wr_ready), 32'(pend_q.size() != WB_DEPTH));
    checkOutput("pending_count", 32'(bus.pending_count), 32'(pend_q.size()));
    checkOutput("rf_write_enable", 32'(bus.rf_write_enable), 32'(drain));
    if (drain) begin
      checkOutput("rf_address_1", 32'(bus.rf_address_1), 32'(pend_q[0].address));
      checkOutput("rf_write_data", bus.rf_write_data, pend_q[0].data);
    end
    checkOutput("rf_address_2", 32'(bus.rf_address_2), 32'(ra));
    if (rv) last_rsp = modelRead(ra);
    @(posedge clk);
    if (drain) begin
      ent = pend_q.pop_front();
      ref_rf[ent.address] = ent.data;
    end
    if (accept) pend_q.push_back('{address: wa, data: wd});
    #1;
    checkOutput("rsp_valid", 32'(bus.rsp_valid), 32'(rv));
    checkOutput("rsp_data", bus.rsp_data, last_rsp);
  endtask

  function automatic vec_t mk(input logic wv, input int wa, input int wd,
                              input logic rv, input int ra, input logic de,
                              input logic er, input logic ew, input int ec,
                              input logic ev, input int ed);
    vec_t v;
    v.wv = wv; v.wa = rf_address_t'(wa); v.wd = rf_data_t'(wd);
    v.rv = rv; v.ra = rf_address_t'(ra); v.de = de;
    v.exp_ready = er; v.exp_we = ew; v.exp_cnt = ec;
    v.exp_rspv = ev; v.exp_rspd = rf_data_t'(ed);
    return v;
  endfunction

  initial begin
    logic pr, pw;

    for (int i = 0; i < NUM_REGS; i++) ref_rf[i] = rfInit(i);
    last_rsp         = '0;
    reset_n          = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.wr_address   = '0;
    bus.wr_data      = '0;
    bus.rd_valid     = 1'b0;
    bus.rd_address   = '0;
    bus.drain_enable = 1'b1;

    // Reset state.
    #12;
    checkOutput("reset_pending_count", 32'(bus.pending_count), 32'd0);
    checkOutput("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("reset_rsp_data", bus.rsp_data, 32'd0);
    checkOutput("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    checkOutput("reset_rf_write_enable", 32'(bus.rf_write_enable), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset in the middle of buffered writes and an in-flight response.
    applyStimulus(1'b1, 5'd1, 32'h111, 1'b0, 5'd0, 1'b0, pr, pw);
    applyStimulus(1'b1, 5'd2, 32'h222, 1'b1, 5'd1, 1'b0, pr, pw);
    reset_n = 1'b0;
    bus.wr_valid     = 1'b0;
    bus.rd_valid     = 1'b0;
    bus.drain_enable = 1'b1;
    #1;
    checkOutput("midreset_pending_count", 32'(bus.pending_count), 32'd0);
    checkOutput("midreset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    pend_q.delete();
    last_rsp = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, pr, pw);
    checkOutput("midreset_r1_discarded", bus.rsp_data, 32'hA000_0001);

    // Directed vector table for the listed corner cases.
    tbl.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 3, 1, 1, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk(1, 5, 32'h11, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 5, 32'h22, 0, 0, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 0, 1, 0, 2, 1, 32'h22));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 5, 1, 1, 1, 0, 1, 32'h22));
    tbl.push_back(mk(0, 0, 0, 1, 5, 1, 1, 0, 0, 1, 32'h22));
    tbl.push_back(mk(1, 7, 32'h5, 0, 0, 1, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(1, 7, 32'h9, 1, 7, 0, 1, 0, 1, 1, 32'h5));
    tbl.push_back(mk(0, 0, 0, 1, 7, 1, 1, 1, 0, 1, 32'h9));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 10 + k, 32'h100 + k, 0, 0, 0, 1, 0, k + 1, 0, 0));
    tbl.push_back(mk(1, 14, 32'hBAD, 0, 0, 0, 0, 0, 4, 0, 0));
    tbl.push_back(mk(1, 14, 32'hBAD, 0, 0, 1, 0, 1, 3, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 14, 1, 1, 0, 0, 1, 32'hA000_000E));
    tbl.push_back(mk(1, 20, 32'h200, 0, 0, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 21, 32'h201, 0, 0, 0, 1, 0, 2, 0, 0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 22 + k, 32'h202 + k, 0, 0, 1, 1, 1, 2, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 29, 1, 1, 0, 0, 1, 32'h209));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].rv, tbl[i].ra,
                    tbl[i].de, pr, pw);
      checkOutput($sformatf("vec%0d_ready", i), 32'(pr), 32'(tbl[i].exp_ready));
      checkOutput($sformatf("vec%0d_we", i), 32'(pw), 32'(tbl[i].exp_we));
      checkOutput($sformatf("vec%0d_count", i), 32'(bus.pending_count),
                  32'(tbl[i].exp_cnt));
      checkOutput($sformatf("vec%0d_rsp_valid", i), 32'(bus.rsp_valid),
                  32'(tbl[i].exp_rspv));
      if (tbl[i].exp_rspv)
        checkOutput($sformatf("vec%0d_rsp_data", i), bus.rsp_data, tbl[i].exp_rspd);
    end

    // Randomised traffic on a few registers to provoke hazards and fullness.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), rf_address_t'($urandom_range(0, 7)),
                    rf_data_t'($urandom), 1'($urandom_range(0, 1)),
                    rf_address_t'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) != 0), pr, pw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/register_file_access_controller.md
Name: register_file_access_controller

Overview:
- Initiator-side front end for data_register_file: drives its write port (write_enable, address_1, write_data) and read port (address_2), and consumes read_data.
- Buffers processor writeback requests in a small in-order FIFO and drains them into the register file one per cycle.
- Serves processor reads with registered responses, forwarding pending buffered writes so reads always see the youngest architectural value.

Parameters:
ADDRESS_WIDTH, 5, register address width; matches data_register_file address width.
DATA_WIDTH, 32, register data width.
WB_DEPTH, 4, writeback FIFO entries; power of two, >= 2.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
wr_valid  input  1  writeback request valid.
wr_ready  output  1  writeback request accepted when high together with wr_valid.
wr_address  input  ADDRESS_WIDTH  writeback destination register.
wr_data  input  DATA_WIDTH  writeback value.
rd_valid  input  1  read request valid; always accepted.
rd_address  input  ADDRESS_WIDTH  register to read.
rsp_valid  output  1  read response valid; one-cycle pulse.
rsp_data  output  DATA_WIDTH  read response value.
drain_enable  input  1  1 = FIFO may write into the register file this cycle.
rf_write_enable  output  1  to data_register_file write_enable.
rf_address_1  output  ADDRESS_WIDTH  to data_register_file write address.
rf_write_data  output  DATA_WIDTH  to data_register_file write data.
rf_address_2  output  ADDRESS_WIDTH  to data_register_file read address.
rf_read_data  input  DATA_WIDTH  from data_register_file; combinational read of rf_address_2.
pending_count  output  $clog2(WB_DEPTH+1)  number of buffered writes.

Behaviour:
- Clock and reset: single clock clk. reset_n is asynchronous, active-low.
- Reset: FIFO empty, head/tail pointers 0, pending_count 0, rsp_valid 0, rsp_data 0. rf_write_enable is 0 because the FIFO is empty.
- Reset mid-operation: buffered writes are discarded and never reach the register file. An in-flight read response is dropped.
- Write accept: wr_ready = (pending_count != WB_DEPTH), computed from registered state only.
  - A full FIFO deasserts wr_ready even in a cycle where it drains; there is no pass-through.
  - An accepted write is enqueued at the tail at the clock edge.
- Drain:
  - rf_write_enable = drain_enable && !empty.
  - rf_address_1 and rf_write_data come combinationally from the head entry.
  - The head pops at the same clock edge at which the register file captures it.
  - At most one drain per cycle, in strict enqueue order.
- Count: pending_count increments on enqueue only, decrements on drain only, and is unchanged when both occur in the same cycle.
- Pointers wrap modulo WB_DEPTH. Empty and full are distinguished by the count.
- Read path:
  - rf_address_2 = rd_address, driven unconditionally.
  - A read accepted in cycle N gives rsp_valid = 1 in cycle N+1. rsp_valid = 0 otherwise.
  - rsp_data is registered at the N+1 edge and holds its value until the next response.
- Forwarding:
  - If any FIFO entry valid in cycle N matches rd_address, rsp_data takes the data of the youngest matching entry. Otherwise it takes rf_read_data.
  - The head entry being written in cycle N is still a FIFO entry and is forwarded.
- Same-cycle write enqueue and read of the same address: the read returns the pre-write value; the new write is not yet visible.
- Reads never stall and have no backpressure; one read per cycle sustained.
- Duplicate addresses in the FIFO are legal. Each drains in order, so the last one wins in the register file.

Decomposition:
- Shared package rf_access_pkg: typedefs rf_address_t (logic [ADDRESS_WIDTH-1:0]), rf_data_t, and a wb_entry_t struct {address, data}. Default width constants live here.
- One sub-module, writeback_fifo: entry storage, pointers, count, full/empty, and a per-entry valid/address/data view.
- The top level holds the youngest-match forwarding mux, the response register and register-file port wiring.

Test Plan:
- Reset mid-drain: enqueue writes to r1 and r2, hold drain_enable=0, assert reset_n=0 -> pending_count=0, rsp_valid=0. After release, a read of r1 returns the prior register-file value, not the discarded write.
- Basic write/read: drain_enable=1, write r3=0xDEADBEEF -> rf_write_enable=1 the next cycle with rf_address_1=3. A later read of r3 gives rsp_valid one cycle after the request with rsp_data=0xDEADBEEF.
- Fill to full: drain_enable=0, push 4 writes -> pending_count=4, wr_ready=0, a 5th push is not accepted. Set drain_enable=1 -> four consecutive rf_write_enable cycles in enqueue order.
- Forwarding youngest: drain_enable=0, write r5=0x11 then r5=0x22, then read r5 -> rsp_data=0x22. Drain both, read r5 -> 0x22 from the register file.
- Same-cycle hazard: register r7=0x5 in the register file, FIFO empty. In one cycle, write r7=0x9 and read r7 -> rsp_data=0x5. A read the next cycle -> 0x9.
- Simultaneous enqueue and drain at pending_count=2 -> pending_count stays 2 and the order is preserved across pointer wrap-around (8 or more total writes).
